// File: rtl/cdc_pkg.sv
// Shared types for the CDC FIFO read-side stream adapter.
package cdc_pkg;

    localparam int BUF_DEPTH = 2;

    typedef logic [1:0] buf_level_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry in-order skid store; entry 0 is always the head so the stream data is a flop output.
module stream_fifo2
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output buf_level_t            level_o
);

    logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    buf_level_t            level_q, level_d;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        level_d = buf_level_t'(level_q + buf_level_t'(push_i) - buf_level_t'(pop_i));
        if (pop_i) e0_d = e1_q;
        // A word lands in the head slot whenever the head is (or becomes) free this cycle.
        if (push_i) begin
            if (level_q == 2'd0 || (level_q == 2'd1 && pop_i)) e0_d = data_i;
            else                                                e1_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e0_q    <= '0;
            e1_q    <= '0;
            level_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            level_q <= level_d;
        end
    end

    assign head_o  = e0_q;
    assign level_o = level_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && level_q == buf_level_t'(BUF_DEPTH)));

endmodule

// File: rtl/cdc_fifo_stream_adapter.sv
// Read-domain adapter: pulls words from cdc_async_fifo and presents a valid/ready stream.
// Optional frame LAST tagging is enabled by defining CDC_FIFO_STREAM_LAST_EN.
module cdc_fifo_stream_adapter
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 640
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic [1:0]            level_o
);

    if (FRAME_LEN < 1) begin : g_bad_frame_len
        $error("FRAME_LEN must be >= 1");
    end

    logic       pop;
    logic       inflight_q;
    buf_level_t level;
    logic [2:0] occupancy;

    assign pop       = m_valid_o & m_ready_i;
    assign occupancy = {1'b0, level} + {2'b0, inflight_q};

    // Reserve a slot for every word in flight; a same-cycle pop frees one, hence the ready path.
    assign fifo_rd_en_o = rst_ni & ~fifo_empty_i & ((occupancy < 3'(BUF_DEPTH)) | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) inflight_q <= 1'b0;
        else         inflight_q <= fifo_rd_en_o;
    end

    stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (inflight_q),
        .data_i  (fifo_rd_data_i),
        .pop_i   (pop),
        .head_o  (m_data_o),
        .level_o (level)
    );

    assign m_valid_o = (level != '0);
    assign level_o   = level;

`ifdef CDC_FIFO_STREAM_LAST_EN
    localparam int              CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop) cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign m_last_o = m_valid_o & (cnt_q == LAST_CNT);
`else
    assign m_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_fifo_stream_adapter.sv
// Scoreboard bench for cdc_fifo_stream_adapter with a behavioural 1-cycle-latency FIFO.
module tb_cdc_fifo_stream_adapter;

    localparam int DW = 16;
`ifdef CDC_FIFO_STREAM_LAST_EN
    localparam int FL = 4;
`else
    localparam int FL = 640;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic [1:0]    level;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            n_last = 0;
    logic          mon_en = 1'b0;

    always #5 clk = ~clk;

    assign empty = (wr_cnt == rd_cnt);

    cdc_fifo_stream_adapter #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fifo_rd_en_o   (rd_en),
        .fifo_rd_data_i (rd_data),
        .fifo_empty_i   (empty),
        .m_data_o       (m_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_last_o       (m_last),
        .level_o        (level)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // FIFO model: shares the adapter's reset, data due one clock after an accepted read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            rd_cnt <= wr_cnt;
        end else if (rd_en && fifo_q.size() != 0) begin
            rd_data <= fifo_q.pop_front();
            rd_cnt  <= rd_cnt + 1;
        end
    end

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    int            beat       = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            beat       = 0;
        end else if (mon_en) begin
            if (rd_en) chk("underflow", {31'b0, empty}, 32'd0);
            if (prev_stall) begin
                chk("stall_valid", {31'b0, m_valid}, 32'd1);
                chk("stall_data", {16'b0, m_data}, {16'b0, prev_data});
                chk("stall_last", {31'b0, m_last}, {31'b0, prev_last});
            end
            if (m_valid) begin
`ifdef CDC_FIFO_STREAM_LAST_EN
                chk("last", {31'b0, m_last}, {31'b0, (beat % FL) == FL - 1});
`else
                chk("last", {31'b0, m_last}, 32'd0);
`endif
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
                else                   chk("data", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
                if (m_last) n_last++;
                beat++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        wr_cnt++;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk({tag, "_timeout"}, {31'b0, k >= 5000}, 32'd0);
        chk({tag, "_left"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int lat;
        int last0;

        // 1: reset and idle with an empty FIFO
        repeat (2) step();
        chk("rst_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_data", {16'b0, m_data}, 32'd0);
        chk("rst_rden", {31'b0, rd_en}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_valid", {31'b0, m_valid}, 32'd0);
            chk("idle_rden", {31'b0, rd_en}, 32'd0);
            chk("idle_level", {30'b0, level}, 32'd0);
        end

        // 2: 16 words, consumer always ready
        step();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(DW'(i));
        lat = 0;
        @(negedge clk);
        while (!m_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("first_latency", lat, 32'd2);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk("no_bubble", {31'b0, m_valid}, 32'd1);
        end
        drain("t2");

        // 3: consumer stalled, buffer saturates then read requests stop
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DW'(16'h0100 + i));
        repeat (4) @(negedge clk);
        chk("sat_level", {30'b0, level}, 32'd2);
        chk("sat_rden", {31'b0, rd_en}, 32'd0);
        chk("sat_valid", {31'b0, m_valid}, 32'd1);
        repeat (3) @(negedge clk);
        chk("sat_hold", {30'b0, level}, 32'd2);
        step();
        m_ready = 1'b1;
        drain("t3");

        // 4: random backpressure over 1000 words
        step();
        for (int i = 0; i < 1000; i++) push_word(DW'($urandom));
        k = 0;
        while (exp_q.size() != 0 && k < 20000) begin
            step();
            m_ready = 1'($urandom_range(0, 1));
            k++;
        end
        step();
        m_ready = 1'b1;
        drain("t4");

        // 5: asynchronous reset while the buffer is full
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(16'h0A00 + i));
        repeat (5) @(negedge clk);
        chk("pre_rst_level", {30'b0, level}, 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", {31'b0, m_valid}, 32'd0);
        chk("arst_level", {30'b0, level}, 32'd0);
        chk("arst_data", {16'b0, m_data}, 32'd0);
        chk("arst_rden", {31'b0, rd_en}, 32'd0);
        chk("arst_last", {31'b0, m_last}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, m_valid}, 32'd0);
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(DW'(16'h0B00 + i));
        drain("t5");

        // 6: frame LAST tagging over 12 beats from a clean counter
        do_reset();
        last0 = n_last;
        step();
        for (int i = 0; i < 12; i++) push_word(DW'(16'h0C00 + i));
        drain("t6");
`ifdef CDC_FIFO_STREAM_LAST_EN
        chk("last_count", n_last - last0, 32'd3);
`else
        chk("last_count", n_last - last0, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
